r_decode_gen: RTL

R_DECODE_GEN -- requirements
Module: r_decode_gen

---
 rtl/r_decode_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/r_decode_gen.sv
// Header-stripping burst decoder: realigns data beats behind a one-beat header
// and checks the burst length against the header's beat-count field.
module r_decode_gen #(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned HDR_W    = 24,
  parameter int unsigned HDR_DROP = 4,
  parameter int unsigned LEN_LSB  = 0,
  parameter int unsigned LEN_W    = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [DATA_W-1:0]                    in_data,
  input  logic                                 in_last,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [DATA_W+HDR_W-HDR_DROP+2-1:0]   out_r,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [31:0]                          pkt_cnt,
  output logic [15:0]                          err_cnt
);

  localparam int unsigned HW = HDR_W - HDR_DROP;
  localparam int unsigned CW = DATA_W - HDR_W;
  localparam int unsigned OW = DATA_W + HW + 2;

  typedef enum logic [2:0] {
    ST_HDR   = 3'b001,
    ST_DATA  = 3'b010,
    ST_DRAIN = 3'b100
  } state_e;

  state_e            state_q, state_d;
  logic [HW-1:0]     hdr_q, hdr_d;
  logic [CW-1:0]     carry_q, carry_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [OW-1:0]     out_r_q, out_r_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;

  logic              accept;
  logic [LEN_W-1:0]  len;
  logic              emit, emit_last, emit_err;
  logic [HW-1:0]     emit_hdr;
  logic [DATA_W-1:0] emit_data;

  assign in_ready = reset_n & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign len      = hdr_q[LEN_LSB +: LEN_W];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_HDR;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HDR:   if (accept && !in_last) state_d = ST_DATA;
      ST_DATA: begin
        if (accept) begin
          if (in_last)           state_d = ST_HDR;
          else if (cnt_q == len) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (accept && in_last) state_d = ST_HDR;
      default:  state_d = ST_HDR;
    endcase
  end

  // Datapath and output beat formation
  always_comb begin
    hdr_d     = hdr_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_err  = 1'b0;
    emit_hdr  = hdr_q;
    emit_data = '0;
    unique case (state_q)
      ST_HDR: begin
        if (accept) begin
          hdr_d    = in_data[HDR_W-1:HDR_DROP];
          carry_d  = in_data[DATA_W-1:HDR_W];
          cnt_d    = '0;
          emit_hdr = in_data[HDR_W-1:HDR_DROP];
          // Header-only packet: flag it with an empty errored beat
          if (in_last) begin
            emit      = 1'b1;
            emit_last = 1'b1;
            emit_err  = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          emit      = 1'b1;
          emit_data = {in_data[HDR_W-1:0], carry_q};
          carry_d   = in_data[DATA_W-1:HDR_W];
          cnt_d     = cnt_q + LEN_W'(1);
          if (in_last) begin
            emit_last = 1'b1;
            emit_err  = (cnt_q != len);
          end else if (cnt_q == len) begin
            emit_last = 1'b1;
            emit_err  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output register and statistics
  always_comb begin
    out_r_d     = out_r_q;
    out_valid_d = out_valid_q & ~out_ready;
    pkt_cnt_d   = pkt_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (emit) begin
      out_r_d     = {emit_last, emit_err, emit_hdr, emit_data};
      out_valid_d = 1'b1;
      if (emit_last) pkt_cnt_d = pkt_cnt_q + 32'd1;
      if (emit_err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_q       <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      hdr_q       <= hdr_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_r     = out_r_q;
  assign out_valid = out_valid_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
